lr_sample_loader: RTL and testbench

Upstream feeder for the linear-regression SGD trainer. Accepts training samples as a word-serial stream (four 8.8 signed features, then one 8.8 label), holds them in an internal buffer, and replays them one complete sample per handshake, epoch after epoch, for a programmed number of epochs. The trainer consumes `x_out`/`y_out` in parallel, so it no longer needs a hard-coded `initial` data set.

---
 rtl/lr_sample_loader.sv | 185 ++++++++++++++++++
 tb/tb_lr_sample_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lr_sample_loader.sv
// Sample buffer for the linear-regression SGD trainer: word-serial load, then epoch-by-epoch replay.
// Build macro LR_LOADER_ROTATE_EN makes each epoch start one buffer index later than the previous one.
module lr_sample_loader #(
   parameter int NUM_FEATURES = 4,
   parameter int MAX_DP       = 8,
   parameter int DW           = 16
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [DW-1:0]              wr_data,
   input  logic [3:0]                 num_dp,
   input  logic [7:0]                 num_epochs,
   input  logic                       start,
   output logic                       sample_valid,
   input  logic                       sample_ready,
   output logic [NUM_FEATURES*DW-1:0] x_out,
   output logic [DW-1:0]              y_out,
   output logic [2:0]                 sample_idx,
   output logic                       last_in_epoch,
   output logic [7:0]                 epoch_cnt,
   output logic [3:0]                 loaded,
   output logic                       busy,
   output logic                       done,
   output logic                       load_err
);
   localparam int WPS   = NUM_FEATURES + 1;
   localparam int NWORD = MAX_DP * WPS;
   localparam int AW    = $clog2(NWORD);
   localparam int WW    = $clog2(WPS);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic [WW-1:0]               w_q, w_d;
   logic [3:0]                  loaded_q, loaded_d;
   logic                        load_err_q, load_err_d;
   logic [3:0]                  ndp_q, ndp_d;
   logic [7:0]                  nep_q, nep_d;
   logic [7:0]                  epoch_q, epoch_d;
   logic [2:0]                  pos_q, pos_d;
   logic [2:0]                  base_q, base_d;
   logic [NUM_FEATURES*DW-1:0]  x_q, x_d;
   logic [DW-1:0]               y_q, y_d;

   logic [DW-1:0] mem [NWORD];
   logic          mem_we, load_out, wr_drop, start_ok, pos_last;
   logic [AW-1:0] wr_addr, rd_base;
   logic [2:0]    rd_idx;

   // Position within the epoch plus the epoch's starting offset, folded into the buffer range.
   function automatic logic [2:0] idx_of(input logic [2:0] b, input logic [2:0] p,
                                         input logic [3:0] n);
      logic [3:0] s;
      s = {1'b0, b} + {1'b0, p};
      if (s >= n) s = s - n;
      return s[2:0];
   endfunction

   assign wr_addr = AW'(int'(loaded_q) * WPS + int'(w_q));

   always_comb begin
      // NOTE: every always_comb target gets a default first so no latch can be inferred.
      state_d    = state_q;
      w_d        = w_q;
      loaded_d   = loaded_q;
      load_err_d = load_err_q;
      ndp_d      = ndp_q;
      nep_d      = nep_q;
      epoch_d    = epoch_q;
      pos_d      = pos_q;
      base_d     = base_q;
      x_d        = x_q;
      y_d        = y_q;
      mem_we     = 1'b0;
      load_out   = 1'b0;
      rd_idx     = '0;
      rd_base    = '0;
      wr_drop    = wr_en && (loaded_q == 4'(MAX_DP));
      start_ok   = (num_dp != 4'd0) && (num_dp <= loaded_q);
      pos_last   = ({1'b0, pos_q} == ndp_q - 4'd1);

      if (clr) begin
         state_d    = S_IDLE;
         w_d        = '0;
         loaded_d   = '0;
         load_err_d = 1'b0;
      end else if (state_q == S_STREAM) begin
         if (sample_ready) begin
            load_out = 1'b1;
            if (pos_last) begin
               pos_d   = '0;
               epoch_d = (epoch_q == 8'hFF) ? epoch_q : epoch_q + 8'd1;
`ifdef LR_LOADER_ROTATE_EN
               base_d  = ({1'b0, base_q} + 4'd1 == ndp_q) ? 3'd0 : base_q + 3'd1;
`else
               base_d  = '0;
`endif
               if (nep_q != 8'd0 && {1'b0, epoch_q} + 9'd1 == {1'b0, nep_q})
                  state_d = S_DONE;
            end else begin
               pos_d = pos_q + 3'd1;
            end
         end
      end else begin
         if (wr_en && !wr_drop) begin
            mem_we = 1'b1;
            if (w_q == WW'(NUM_FEATURES)) begin
               w_d      = '0;
               loaded_d = loaded_q + 4'd1;
            end else begin
               w_d = w_q + WW'(1);
            end
         end
         if (start && start_ok) begin
            state_d    = S_STREAM;
            ndp_d      = num_dp;
            nep_d      = num_epochs;
            epoch_d    = '0;
            pos_d      = '0;
            base_d     = '0;
            load_out   = 1'b1;
            load_err_d = wr_drop;
         end else if (start || wr_drop) begin
            load_err_d = 1'b1;
         end
      end

      // The next presented sample is fetched ahead so the outputs come straight from flops.
      if (load_out) begin
         rd_idx  = idx_of(base_d, pos_d, ndp_d);
         rd_base = AW'(int'(rd_idx) * WPS);
         for (int k = 0; k < NUM_FEATURES; k++)
            x_d[k*DW +: DW] = mem[rd_base + AW'(k)];
         y_d = mem[rd_base + AW'(NUM_FEATURES)];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         w_q        <= '0;
         loaded_q   <= '0;
         load_err_q <= 1'b0;
         ndp_q      <= '0;
         nep_q      <= '0;
         epoch_q    <= '0;
         pos_q      <= '0;
         base_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         loaded_q   <= loaded_d;
         load_err_q <= load_err_d;
         ndp_q      <= ndp_d;
         nep_q      <= nep_d;
         epoch_q    <= epoch_d;
         pos_q      <= pos_d;
         base_q     <= base_d;
         x_q        <= x_d;
         y_q        <= y_d;
      end
   end

   // NOTE: the buffer has no reset; only entries below the loaded count are ever presented.
   always_ff @(posedge CLK) begin
      if (mem_we) mem[wr_addr] <= wr_data;
   end

   assign sample_valid  = (state_q == S_STREAM);
   assign busy          = (state_q == S_STREAM);
   assign done          = (state_q == S_DONE);
   assign x_out         = x_q;
   assign y_out         = y_q;
   assign sample_idx    = idx_of(base_q, pos_q, ndp_q);
   assign last_in_epoch = busy && pos_last;
   assign epoch_cnt     = epoch_q;
   assign loaded        = loaded_q;
   assign load_err      = load_err_q;

endmodule

// File: tb/tb_lr_sample_loader.sv
// Self-checking bench for lr_sample_loader: directed steps with randomized data and ready patterns,
// checked against a word-list reference model of the sample buffer and epoch replay order.
module tb_lr_sample_loader;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        clr = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic [3:0]  num_dp = '0;
   logic [7:0]  num_epochs = '0;
   logic        start = 1'b0;
   logic        sample_ready = 1'b0;
   logic        sample_valid;
   logic [63:0] x_out;
   logic [15:0] y_out;
   logic [2:0]  sample_idx;
   logic        last_in_epoch;
   logic [7:0]  epoch_cnt;
   logic [3:0]  loaded;
   logic        busy;
   logic        done;
   logic        load_err;

`ifdef LR_LOADER_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [15:0] ref_words[$];
   bit          ref_err = 1'b0;
   bit          chk_s2  = 1'b0;

   logic [15:0] ts [20] = '{16'h0200, 16'h0400, 16'h0300, 16'h0600, 16'h0F00,
                            16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h1200,
                            16'h0900, 16'h0100, 16'h0200, 16'h0300, 16'h0F00,
                            16'h0700, 16'h0800, 16'h0000, 16'h0100, 16'h1000};

   always #5 CLK = ~CLK;

   lr_sample_loader dut (
      .CLK(CLK), .RST(RST), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
      .num_dp(num_dp), .num_epochs(num_epochs), .start(start),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .x_out(x_out), .y_out(y_out), .sample_idx(sample_idx),
      .last_in_epoch(last_in_epoch), .epoch_cnt(epoch_cnt), .loaded(loaded),
      .busy(busy), .done(done), .load_err(load_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr_word(input logic [15:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en   = 1'b0;
      if (ref_words.size() < 40) ref_words.push_back(w);
      else ref_err = 1'b1;
   endtask

   task automatic clr_buf();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      ref_words.delete();
      ref_err = 1'b0;
   endtask

   task automatic load_set();
      for (int i = 0; i < 20; i++) wr_word(ts[i]);
   endtask

   task automatic load_random(input int nwords);
      for (int i = 0; i < nwords; i++) wr_word(16'($urandom));
   endtask

   task automatic check_loaded(input string tag);
      check({tag, "_loaded"}, loaded, ref_words.size() / 5);
      check({tag, "_load_err"}, load_err, ref_err);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, sample_valid, 0);
      check({tag, "_x"}, x_out, 0);
      check({tag, "_y"}, y_out, 0);
      check({tag, "_idx"}, sample_idx, 0);
      check({tag, "_last"}, last_in_epoch, 0);
      check({tag, "_epoch"}, epoch_cnt, 0);
      check({tag, "_loaded"}, loaded, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_load_err"}, load_err, 0);
   endtask

   function automatic logic [63:0] exp_x(input int s);
      logic [63:0] v;
      for (int f = 0; f < 4; f++) v[f*16 +: 16] = ref_words[s*5 + f];
      return v;
   endfunction

   // mode 0: ready held high; 1: ready pattern 1,0,0,1 repeating; 2: random ready
   task automatic run_stream(input string tag, input int ndp, input int nep, input int mode);
      int   e, j, cyc, exp_idx;
      logic rdy;
      num_dp     = 4'(ndp);
      num_epochs = 8'(nep);
      start      = 1'b1;
      tick();
      start      = 1'b0;
      ref_err    = 1'b0;
      check({tag, "_err_cleared"}, load_err, 0);
      e   = 0;
      j   = 0;
      cyc = 0;
      while (e < nep) begin
         exp_idx = ROT ? ((e % ndp) + j) % ndp : j;
         check({tag, "_valid"}, sample_valid, 1);
         check({tag, "_busy"}, busy, 1);
         check({tag, "_idx"}, sample_idx, exp_idx);
         check({tag, "_x"}, x_out, exp_x(exp_idx));
         check({tag, "_y"}, y_out, ref_words[exp_idx*5 + 4]);
         check({tag, "_last"}, last_in_epoch, (j == ndp - 1));
         check({tag, "_epoch"}, epoch_cnt, e);
         if (chk_s2 && exp_idx == 2) check({tag, "_s2_f0"}, x_out[15:0], 16'h0900);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         sample_ready = rdy;
         tick();
         cyc++;
         if (rdy) begin
            j++;
            if (j == ndp) begin
               j = 0;
               e++;
            end
         end
         if (cyc > 2000) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_timeout: observed %0d cycles expected completion", tag, cyc);
            break;
         end
      end
      sample_ready = 1'b0;
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_valid_end"}, sample_valid, 0);
      check({tag, "_epoch_end"}, epoch_cnt, nep);
   endtask

   initial begin
      #2;
      check_zero("reset");
      tick();
      tick();
      RST = 1'b0;
      tick();

      // Reference set: two epochs back to back, then reruns from DONE without reloading.
      load_set();
      check_loaded("set");
      chk_s2 = 1'b1;
      run_stream("set_full", 4, 2, 0);
      run_stream("set_toggle", 4, 2, 1);
      chk_s2 = 1'b0;
      run_stream("set_rand", 3, 1, 2);

      // Append one random sample while in DONE.
      load_random(5);
      check_loaded("append");
      run_stream("append", 5, 1, 2);

      // Three epochs: rotated start order when the rotate build is selected.
      run_stream("epochs3", 4, 3, 0);

      // Start with too few samples loaded is rejected.
      clr_buf();
      check_loaded("clr");
      load_random(15);
      num_dp = 4'd4;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      ref_err = 1'b1;
      check_loaded("reject");
      check("reject_valid", sample_valid, 0);
      check("reject_busy", busy, 0);
      check("reject_done", done, 0);

      // 41 writes: the last one is dropped, buffer content stays the first 40 words.
      clr_buf();
      load_random(41);
      check_loaded("overflow");
      run_stream("overflow", 8, 1, 2);

      // Run-forever with one sample per epoch: epoch count saturates at 255.
      clr_buf();
      load_random(5);
      num_dp     = 4'd1;
      num_epochs = 8'd0;
      start      = 1'b1;
      tick();
      start        = 1'b0;
      sample_ready = 1'b1;
      repeat (10) tick();
      check("forever_epoch10", epoch_cnt, 10);
      repeat (290) tick();
      check("forever_sat", epoch_cnt, 255);
      check("forever_busy", busy, 1);
      sample_ready = 1'b0;
      clr_buf();
      check("clr_valid", sample_valid, 0);
      check("clr_busy", busy, 0);
      check_loaded("clr2");

      // Reset arrives during the third handshake of epoch 0.
      load_set();
      num_dp     = 4'd4;
      num_epochs = 8'd2;
      start      = 1'b1;
      tick();
      start        = 1'b0;
      sample_ready = 1'b1;
      tick();
      tick();
      check("pre_rst_idx", sample_idx, 2);
      RST = 1'b1;
      #1;
      check_zero("mid_rst");
      sample_ready = 1'b0;
      ref_words.delete();
      ref_err = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      tick();
      load_set();
      check_loaded("reload");
      run_stream("after_rst", 4, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
